// File: rtl/dvi_tmds_encode_pkg.sv
// Shared TMDS definitions: control tokens, reset symbol and small helpers used by
// the DVI TMDS encoder and its per-channel sub-module.
package dvi_tmds_encode_pkg;

   localparam logic [9:0] TMDS_CTRL_00   = 10'h354;
   localparam logic [9:0] TMDS_CTRL_01   = 10'h0AB;
   localparam logic [9:0] TMDS_CTRL_10   = 10'h154;
   localparam logic [9:0] TMDS_CTRL_11   = 10'h2AB;
   localparam logic [9:0] TMDS_RESET_SYM = TMDS_CTRL_00;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] sum;
      sum = '0;
      for (int i = 0; i < 8; i++) sum = sum + {3'b000, v[i]};
      return sum;
   endfunction

   // Token selected by {C1,C0}
   function automatic logic [9:0] tmds_ctrl_token(input logic [1:0] c);
      logic [9:0] tok;
      case (c)
         2'b00:   tok = TMDS_CTRL_00;
         2'b01:   tok = TMDS_CTRL_01;
         2'b10:   tok = TMDS_CTRL_10;
         default: tok = TMDS_CTRL_11;
      endcase
      return tok;
   endfunction

endpackage

// File: rtl/dvi_tmds_encode_channel.sv
// One TMDS channel (tmds_channel_enc role): 8b/10b data encode with running
// disparity, control tokens when de=0. Optional output register: TMDS_OUTREG_EN.
module dvi_tmds_encode_channel
   import dvi_tmds_encode_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       de,
   input  logic       c0,
   input  logic       c1,
   input  logic [7:0] d,
   output logic [9:0] sym
);

   logic [3:0]        n1_d;
   logic              use_xnor;
   logic [8:0]        q_m_d;
   logic [8:0]        q_m_r;
   logic              de_r;
   logic [1:0]        ctrl_r;

   logic [3:0]        n1_q;
   logic              q8;
   logic signed [5:0] diff;
   logic signed [5:0] cnt_ext;
   logic signed [5:0] cnt_d;
   logic signed [4:0] cnt;
   logic [9:0]        sym_d;
   logic [9:0]        sym_s2;

   // Stage 1: transition-minimising q_m
   always_comb begin
      n1_d     = popcount8(d);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
      q_m_d    = '0;
      q_m_d[0] = d[0];
      for (int i = 1; i < 8; i++)
         q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d[i]) : (q_m_d[i-1] ^ d[i]);
      q_m_d[8] = !use_xnor;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_m_r  <= '0;
         de_r   <= 1'b0;
         ctrl_r <= 2'b00;
      end else begin
         q_m_r  <= q_m_d;
         de_r   <= de;
         ctrl_r <= {c1, c0};
      end
   end

   // Stage 2: DC balancing; diff is ones minus zeros of q_m[7:0]
   always_comb begin
      n1_q    = popcount8(q_m_r[7:0]);
      q8      = q_m_r[8];
      diff    = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
      cnt_ext = {cnt[4], cnt};
      sym_d   = TMDS_RESET_SYM;
      cnt_d   = '0;
      if (!de_r) begin
         sym_d = tmds_ctrl_token(ctrl_r);
         cnt_d = '0;
      end else if ((cnt == 5'sd0) || (n1_q == 4'd4)) begin
         sym_d = {~q8, q8, (q8 ? q_m_r[7:0] : ~q_m_r[7:0])};
         cnt_d = q8 ? (cnt_ext + diff) : (cnt_ext - diff);
      end else if ((!cnt[4] && (n1_q > 4'd4)) || (cnt[4] && (n1_q < 4'd4))) begin
         sym_d = {1'b1, q8, ~q_m_r[7:0]};
         cnt_d = cnt_ext + (q8 ? 6'sd2 : 6'sd0) - diff;
      end else begin
         sym_d = {1'b0, q8, q_m_r[7:0]};
         cnt_d = cnt_ext + diff - (q8 ? 6'sd0 : 6'sd2);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         sym_s2 <= TMDS_RESET_SYM;
      end else begin
         cnt    <= cnt_d[4:0];
         sym_s2 <= sym_d;
      end
   end

`ifdef TMDS_OUTREG_EN
   logic [9:0] sym_s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sym_s3 <= TMDS_RESET_SYM;
      else     sym_s3 <= sym_s2;
   end

   assign sym = sym_s3;
`else
   assign sym = sym_s2;
`endif

endmodule

// File: rtl/dvi_tmds_encode.sv
// DVI TMDS encoder top: colour widening and control-bit mapping over three
// channel encoders. Optional extra output register stage: TMDS_OUTREG_EN.
module dvi_tmds_encode
   import dvi_tmds_encode_pkg::*;
#(
   parameter int COLOR_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic                  visible_i,
   input  logic                  hsync_i,
   input  logic                  vsync_i,
   input  logic [COLOR_BITS-1:0] red_i,
   input  logic [COLOR_BITS-1:0] green_i,
   input  logic [COLOR_BITS-1:0] blue_i,
   output logic [9:0]            tmds_red_o,
   output logic [9:0]            tmds_green_o,
   output logic [9:0]            tmds_blue_o
);

   // Widen by replication (0xA -> 0xAA); COLOR_BITS must divide 8
   logic [7:0] red8;
   logic [7:0] green8;
   logic [7:0] blue8;

   assign red8   = {(8 / COLOR_BITS){red_i}};
   assign green8 = {(8 / COLOR_BITS){green_i}};
   assign blue8  = {(8 / COLOR_BITS){blue_i}};

   dvi_tmds_encode_channel u_ch0_blue (
      .clk (clk),
      .rst (reset_i),
      .de  (visible_i),
      .c0  (hsync_i),
      .c1  (vsync_i),
      .d   (blue8),
      .sym (tmds_blue_o)
   );

   // DVI only: no data islands, so green and red always carry token 00
   dvi_tmds_encode_channel u_ch1_green (
      .clk (clk),
      .rst (reset_i),
      .de  (visible_i),
      .c0  (1'b0),
      .c1  (1'b0),
      .d   (green8),
      .sym (tmds_green_o)
   );

   dvi_tmds_encode_channel u_ch2_red (
      .clk (clk),
      .rst (reset_i),
      .de  (visible_i),
      .c0  (1'b0),
      .c1  (1'b0),
      .d   (red8),
      .sym (tmds_red_o)
   );

endmodule

// File: tb/tb_dvi_tmds_encode.sv
// Bench for dvi_tmds_encode: directed sync/colour cases, random pixels against an
// integer reference encoder, decode round-trip and async reset mid-line.
module tb_dvi_tmds_encode;

`ifdef TMDS_OUTREG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic       clk;
   logic       reset_i;
   logic       visible_i;
   logic       hsync_i;
   logic       vsync_i;
   logic [3:0] red_i;
   logic [3:0] green_i;
   logic [3:0] blue_i;
   logic [9:0] tmds_red_o;
   logic [9:0] tmds_green_o;
   logic [9:0] tmds_blue_o;

   int tests;
   int fails;
   int mcnt [3];
   int max_abs_cnt;
   // {visible, red8, green8, blue8, red sym, green sym, blue sym}
   logic [54:0] exp_q[$];

   dvi_tmds_encode #(.COLOR_BITS(4)) dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .visible_i    (visible_i),
      .hsync_i      (hsync_i),
      .vsync_i      (vsync_i),
      .red_i        (red_i),
      .green_i      (green_i),
      .blue_i       (blue_i),
      .tmds_red_o   (tmds_red_o),
      .tmds_green_o (tmds_green_o),
      .tmds_blue_o  (tmds_blue_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference encoder with integer disparity bookkeeping
   function automatic logic [9:0] ref_enc(input int ch, input bit de, input bit [1:0] c,
                                          input logic [7:0] d);
      logic [9:0] tok [4];
      logic [8:0] qm;
      int n1d, n1, n0;
      bit xn;
      logic [9:0] s;
      tok = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
      if (!de) begin
         mcnt[ch] = 0;
         return tok[c];
      end
      n1d = $countones(d);
      xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (mcnt[ch] == 0 || n1 == n0) begin
         s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         mcnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
      end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         mcnt[ch] += 2 * int'(qm[8]) + n0 - n1;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         mcnt[ch] += n1 - n0 - 2 * int'(!qm[8]);
      end
      if (mcnt[ch] > max_abs_cnt) max_abs_cnt = mcnt[ch];
      if (-mcnt[ch] > max_abs_cnt) max_abs_cnt = -mcnt[ch];
      return s;
   endfunction

   // Receiver-side decode back to the 8-bit value
   function automatic logic [7:0] tmds_dec(input logic [9:0] s);
      logic [7:0] dd;
      logic [7:0] o;
      dd = s[9] ? ~s[7:0] : s[7:0];
      o[0] = dd[0];
      for (int i = 1; i < 8; i++) o[i] = s[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
      return o;
   endfunction

   task automatic drive(input bit vis, input bit hs, input bit vs,
                        input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      logic [7:0] r8, g8, b8;
      logic [9:0] er, eg, eb;
      @(negedge clk);
      visible_i = vis;
      hsync_i   = hs;
      vsync_i   = vs;
      red_i     = r;
      green_i   = g;
      blue_i    = b;
      if (!reset_i) begin
         r8 = 8'(r * 17);
         g8 = 8'(g * 17);
         b8 = 8'(b * 17);
         eb = ref_enc(0, vis, {vs, hs}, b8);
         eg = ref_enc(1, vis, 2'b00, g8);
         er = ref_enc(2, vis, 2'b00, r8);
         exp_q.push_back({vis, r8, g8, b8, er, eg, eb});
      end
   endtask

   task automatic check_reset_outs(input string name);
      tests++;
      if (tmds_red_o !== 10'h354 || tmds_green_o !== 10'h354 || tmds_blue_o !== 10'h354) begin
         fails++;
         $display("FAIL %s: got r=%h g=%h b=%h, want 354 on all", name,
                  tmds_red_o, tmds_green_o, tmds_blue_o);
      end
   endtask

   task automatic assert_reset_async();
      @(posedge clk);
      #3;
      reset_i = 1'b1;
      exp_q.delete();
      mcnt = '{0, 0, 0};
      #1;
      check_reset_outs("async_reset");
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      reset_i = 1'b0;
   endtask

   // Monitor: pops one expected pixel per output symbol once the pipeline is full
   initial begin
      logic [54:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (reset_i) begin
            check_reset_outs("reset_out");
         end else if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            tests++;
            if (tmds_red_o !== e[29:20] || tmds_green_o !== e[19:10] || tmds_blue_o !== e[9:0]) begin
               fails++;
               $display("FAIL symbol: got r=%h g=%h b=%h, want r=%h g=%h b=%h (vis=%0b)",
                        tmds_red_o, tmds_green_o, tmds_blue_o, e[29:20], e[19:10], e[9:0], e[54]);
            end
            if (e[54]) begin
               tests++;
               if (tmds_dec(tmds_red_o) !== e[53:46] || tmds_dec(tmds_green_o) !== e[45:38] ||
                   tmds_dec(tmds_blue_o) !== e[37:30]) begin
                  fails++;
                  $display("FAIL decode: got r=%h g=%h b=%h, want r=%h g=%h b=%h",
                           tmds_dec(tmds_red_o), tmds_dec(tmds_green_o), tmds_dec(tmds_blue_o),
                           e[53:46], e[45:38], e[37:30]);
               end
            end
         end
      end
   end

   initial begin
      bit vis;
      tests       = 0;
      fails       = 0;
      max_abs_cnt = 0;
      mcnt        = '{0, 0, 0};
      reset_i     = 1'b1;
      visible_i   = 1'b0;
      hsync_i     = 1'b0;
      vsync_i     = 1'b0;
      red_i       = '0;
      green_i     = '0;
      blue_i      = '0;

      // Reset, then idle control period
      repeat (3) @(negedge clk);
      release_reset();
      repeat (4) drive(0, 0, 0, 4'h0, 4'h0, 4'h0);

      // Sync tokens on blue
      repeat (4) drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
      repeat (4) drive(0, 1, 1, 4'h0, 4'h0, 4'h0);
      repeat (2) drive(0, 0, 1, 4'h0, 4'h0, 4'h0);

      // Held black blue and full-scale red from cnt=0
      repeat (6) drive(1, 0, 0, 4'hF, 4'h5, 4'h0);
      repeat (2) drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
      repeat (3) drive(1, 0, 0, 4'hA, 4'h3, 4'hC);
      drive(0, 1, 0, 4'h0, 4'h0, 4'h0);

      // Random pixels with random blanking intervals
      vis = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 99) < 3) vis = !vis;
         drive(vis, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      // Async reset mid-line, then resume from cnt=0
      repeat (5) drive(1, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'h7);
      assert_reset_async();
      repeat (3) drive(1, 0, 0, 4'h9, 4'h9, 4'h9);
      release_reset();
      repeat (4) drive(1, 0, 0, 4'hF, 4'h1, 4'h0);
      repeat (LAT + 1) drive(0, 0, 0, 4'h0, 4'h0, 4'h0);

      tests++;
      if (max_abs_cnt > 8) begin
         fails++;
         $display("FAIL cnt_range: got max |cnt|=%0d, want <= 8", max_abs_cnt);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
